// File: rtl/capture_ctrl_pkg.sv
// Shared definitions for the logic-analyzer capture controller:
// sequencer states and trigger-combine mode encoding.
package capture_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_WAIT,
    ST_POST,
    ST_DONE
  } cap_state_e;

  localparam logic TRIG_MODE_AND = 1'b0;
  localparam logic TRIG_MODE_OR  = 1'b1;

endpackage

// File: rtl/capture_ctrl_trig_combine.sv
// Mask-and-reduce of the per-channel trigger flags into a single hit.
// OR mode with an empty mask never hits; AND mode with an empty mask always hits.
module trig_combine
  import capture_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             trig_or,
  input  logic [WIDTH-1:0] ch_mask,
  input  logic [WIDTH-1:0] trig_vec,
  output logic             hit
);

  always_comb begin
    hit = 1'b0;
    case (trig_or)
      TRIG_MODE_OR:  hit = |(trig_vec & ch_mask);
      TRIG_MODE_AND: hit = &(trig_vec | ~ch_mask);
    endcase
  end

endmodule

// File: rtl/capture_ctrl.sv
// Capture sequencer for the logic-analyzer debugger: arm / pre / wait / post over a circular
// sample RAM. Define CAPTURE_TIMEOUT_EN to force a trigger after TIMEOUT_CYCLES WAIT writes.
//
// state   | meaning
// ST_IDLE | not armed, no RAM writes
// ST_PRE  | writing the pre_depth history samples, trigger ignored
// ST_WAIT | writing every cycle until a hit (or timeout)
// ST_POST | writing post_len samples after the trigger sample
// ST_DONE | buffer complete, trig_addr / start_addr valid
module capture_ctrl
  import capture_ctrl_pkg::*;
#(
  parameter int PORT_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  trig_or,
  input  logic [PORT_WIDTH-1:0] ch_mask,
  input  logic [ADDR_WIDTH-1:0] pre_depth,
  input  logic [PORT_WIDTH-1:0] trig_vec,
  input  logic [PORT_WIDTH-1:0] data_in,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [PORT_WIDTH-1:0] ram_wdata,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic [ADDR_WIDTH-1:0] start_addr,
  output logic                  timed_out
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  cap_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] pre_q, pre_d;
  logic [ADDR_WIDTH-1:0] waddr_d, trig_addr_d, start_addr_d;
  logic [ADDR_WIDTH-1:0] post_len;
  logic                  hit, force_trig, arm_ok, writing_d;

  trig_combine #(.WIDTH(PORT_WIDTH)) u_trig_combine (
    .trig_or  (trig_or),
    .ch_mask  (ch_mask),
    .trig_vec (trig_vec),
    .hit      (hit)
  );

  // pre + trigger + post always fills the whole buffer exactly once.
  assign post_len = ADDR_MAX - pre_q;
  assign arm_ok   = arm && !abort && (state_q == ST_IDLE || state_q == ST_DONE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pre_d        = pre_q;
    waddr_d      = ram_waddr;
    trig_addr_d  = trig_addr;
    start_addr_d = start_addr;
    if (ram_we) waddr_d = ram_waddr + ADDR_ONE;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm_ok) begin
          pre_d   = pre_depth;
          cnt_d   = pre_depth;
          waddr_d = '0;
          state_d = (pre_depth == '0) ? ST_WAIT : ST_PRE;
        end
      end
      ST_PRE: begin
        cnt_d = cnt_q - ADDR_ONE;
        if (cnt_q == ADDR_ONE) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (hit || force_trig) begin
          trig_addr_d  = ram_waddr;
          start_addr_d = ram_waddr - pre_q;
          cnt_d        = post_len;
          state_d      = (post_len == '0) ? ST_DONE : ST_POST;
        end
      end
      ST_POST: begin
        cnt_d = cnt_q - ADDR_ONE;
        if (cnt_q == ADDR_ONE) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
      waddr_d = '0;
    end
  end

  assign writing_d = (state_d == ST_PRE) || (state_d == ST_WAIT) || (state_d == ST_POST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pre_q      <= '0;
      ram_waddr  <= '0;
      ram_wdata  <= '0;
      ram_we     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      trig_addr  <= '0;
      start_addr <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pre_q      <= pre_d;
      ram_waddr  <= waddr_d;
      ram_wdata  <= data_in;
      ram_we     <= writing_d;
      busy       <= writing_d;
      done       <= (state_d == ST_DONE);
      trig_addr  <= trig_addr_d;
      start_addr <= start_addr_d;
    end
  end

`ifdef CAPTURE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;

  // Reloaded on arm, decremented once per WAIT write; terminal count forces the trigger.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                  tmo_q <= '0;
    else if (abort)                             tmo_q <= '0;
    else if (arm_ok)                            tmo_q <= TMO_W'(TIMEOUT_CYCLES);
    else if (state_q == ST_WAIT && tmo_q != '0) tmo_q <= tmo_q - TMO_W'(1);
  end

  assign force_trig = (state_q == ST_WAIT) && (tmo_q == TMO_W'(1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                   timed_out <= 1'b0;
    else if (abort || arm_ok)    timed_out <= 1'b0;
    else if (force_trig && !hit) timed_out <= 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign force_trig     = 1'b0;
  assign timed_out      = 1'b0;
`endif

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl (DEPTH 16, 8 channels, TIMEOUT_CYCLES 8).
// A scoreboard of expected write addresses and delayed data is checked on every RAM write.
`timescale 1ns/1ps
module tb_capture_ctrl;
  localparam int PW  = 8;
  localparam int AW  = 4;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic          trig_or = 1'b0;
  logic [PW-1:0] ch_mask = '0;
  logic [AW-1:0] pre_depth = '0;
  logic [PW-1:0] trig_vec = '0;
  logic [PW-1:0] data_in = '0;
  logic          ram_we, busy, done, timed_out;
  logic [AW-1:0] ram_waddr, trig_addr, start_addr;
  logic [PW-1:0] ram_wdata;

  int checks = 0;
  int passed = 0;
  int wr_count = 0;
  logic [AW-1:0] addr_q[$];
  logic [PW-1:0] data_q[$];

  always #5 clk = ~clk;

  capture_ctrl #(.PORT_WIDTH(PW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rstn(rstn), .arm(arm), .abort(abort), .trig_or(trig_or),
    .ch_mask(ch_mask), .pre_depth(pre_depth), .trig_vec(trig_vec), .data_in(data_in),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .busy(busy),
    .done(done), .trig_addr(trig_addr), .start_addr(start_addr), .timed_out(timed_out)
  );

  // Random probe data; each driven value is queued as the next expected ram_wdata.
  initial begin : data_drv
    data_q.push_back('0);
    forever begin
      @(posedge clk); #1;
      data_in = PW'($urandom);
      data_q.push_back(data_in);
    end
  end

  initial begin : write_monitor
    logic [PW-1:0] exp_d;
    logic [AW-1:0] exp_a;
    forever begin
      @(negedge clk);
      exp_d = '0;
      if (data_q.size() >= 2) exp_d = data_q.pop_front();
      if (ram_we === 1'b1) begin
        wr_count++;
        checks++;
        if (addr_q.size() == 0)
          $display("FAIL wr_unexpected: write at addr %0d, no write expected", ram_waddr);
        else begin
          exp_a = addr_q.pop_front();
          if (ram_waddr !== exp_a || ram_wdata !== exp_d)
            $display("FAIL wr_data: got addr %0d data %h, want addr %0d data %h",
                     ram_waddr, ram_wdata, exp_a, exp_d);
          else passed++;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  task automatic drive_capture(input logic [AW-1:0] pre, input logic mode, input logic [PW-1:0] mask,
                               input logic [PW-1:0] pre_vec, input logic [PW-1:0] hit_vec,
                               input int hit_idx, input int rearm_idx, input int n_writes);
    wr_count = 0;
    for (int i = 0; i < n_writes; i++) addr_q.push_back(AW'(i));
    pre_depth = pre;
    trig_or   = mode;
    ch_mask   = mask;
    trig_vec  = pre_vec;
    arm       = 1'b1;
    @(posedge clk); #1;
    arm       = 1'b0;
    pre_depth = ~pre;
    if (hit_idx < 0) return;
    for (int i = 0; i < hit_idx; i++) begin
      arm = (i == rearm_idx);
      @(posedge clk); #1;
    end
    arm      = 1'b0;
    trig_vec = hit_vec;
    @(posedge clk); #1;
    trig_vec = '0;
  endtask

  task automatic wait_done(input int limit, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < limit) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    arm = 1'b1;
    @(negedge clk);
    checks++; if ({ram_we, busy, done, timed_out} !== 4'b0)
      $display("FAIL reset_flags: got %b, want 0000", {ram_we, busy, done, timed_out}); else passed++;
    checks++; if ({ram_waddr, trig_addr, start_addr} !== 12'h000)
      $display("FAIL reset_addrs: got %h, want 000", {ram_waddr, trig_addr, start_addr}); else passed++;
    checks++; if (ram_wdata !== 8'h00)
      $display("FAIL reset_wdata: got %h, want 00", ram_wdata); else passed++;
    arm = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || ram_we !== 1'b0)
      $display("FAIL reset_idle: got busy %b we %b, want 0 0", busy, ram_we); else passed++;
  endtask

  task automatic test_basic_or();
    int cyc;
    drive_capture(4'd4, 1'b1, 8'h01, 8'hFE, 8'h01, 9, -1, 21);
    wait_done(100, cyc);
    checks++; if (cyc !== 12) $display("FAIL basic_done_time: got %0d cycles, want 12", cyc); else passed++;
    checks++; if (trig_addr !== 4'd9) $display("FAIL basic_trig_addr: got %0d, want 9", trig_addr); else passed++;
    checks++; if (start_addr !== 4'd5) $display("FAIL basic_start_addr: got %0d, want 5", start_addr); else passed++;
    checks++; if (wr_count !== 21) $display("FAIL basic_writes: got %0d, want 21", wr_count); else passed++;
    checks++; if ({done, busy, ram_we, timed_out} !== 4'b1000)
      $display("FAIL basic_flags: got %b, want 1000", {done, busy, ram_we, timed_out}); else passed++;
  endtask

  task automatic test_back_to_back();
    int cyc;
    drive_capture(4'd0, 1'b0, 8'h00, 8'h00, 8'h00, 0, -1, 16);
    wait_done(100, cyc);
    checks++; if (cyc !== 16) $display("FAIL b2b_done_time: got %0d cycles, want 16", cyc); else passed++;
    checks++; if (trig_addr !== 4'd0 || start_addr !== 4'd0)
      $display("FAIL b2b_addrs: got trig %0d start %0d, want 0 0", trig_addr, start_addr); else passed++;
    checks++; if (wr_count !== 16) $display("FAIL b2b_writes: got %0d, want 16", wr_count); else passed++;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL b2b_abort_done: got done %b busy %b, want 0 0", done, busy); else passed++;
  endtask

  task automatic test_wrap();
    int cyc;
    drive_capture(4'd2, 1'b0, 8'h0C, 8'hF4, 8'h0C, 33, 20, 47);
    wait_done(100, cyc);
    checks++; if (cyc !== 14) $display("FAIL wrap_done_time: got %0d cycles, want 14", cyc); else passed++;
    checks++; if (trig_addr !== 4'd1) $display("FAIL wrap_trig_addr: got %0d, want 1", trig_addr); else passed++;
    checks++; if (start_addr !== 4'd15) $display("FAIL wrap_start_addr: got %0d, want 15", start_addr); else passed++;
    checks++; if (wr_count !== 47) $display("FAIL wrap_writes: got %0d, want 47", wr_count); else passed++;
  endtask

  task automatic test_post_zero();
    int cyc;
    drive_capture(4'd15, 1'b1, 8'h80, 8'h00, 8'h80, 15, -1, 16);
    @(negedge clk);
    checks++; if (done !== 1'b1 || ram_we !== 1'b0)
      $display("FAIL post0_done_next: got done %b we %b, want 1 0", done, ram_we); else passed++;
    wait_done(5, cyc);
    checks++; if (trig_addr !== 4'd15 || start_addr !== 4'd0)
      $display("FAIL post0_addrs: got trig %0d start %0d, want 15 0", trig_addr, start_addr); else passed++;
    checks++; if (wr_count !== 16) $display("FAIL post0_writes: got %0d, want 16", wr_count); else passed++;
  endtask

  task automatic test_pre_ignored();
    int cyc;
    drive_capture(4'd3, 1'b0, 8'hFF, 8'hFF, 8'hFF, 3, -1, 16);
    wait_done(100, cyc);
    checks++; if (cyc !== 13) $display("FAIL preign_done_time: got %0d cycles, want 13", cyc); else passed++;
    checks++; if (trig_addr !== 4'd3) $display("FAIL preign_trig_addr: got %0d, want 3", trig_addr); else passed++;
    checks++; if (wr_count !== 16) $display("FAIL preign_writes: got %0d, want 16", wr_count); else passed++;
  endtask

  task automatic test_abort();
    int cyc;
    drive_capture(4'd4, 1'b1, 8'h01, 8'h00, 8'h01, 6, -1, 11);
    repeat (3) begin @(posedge clk); #1; end
    abort = 1'b1;
    arm   = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    arm   = 1'b0;
    @(negedge clk);
    checks++; if ({ram_we, busy, done} !== 3'b000)
      $display("FAIL abort_flags: got %b, want 000", {ram_we, busy, done}); else passed++;
    checks++; if (wr_count !== 11) $display("FAIL abort_writes: got %0d, want 11", wr_count); else passed++;
    abort = 1'b1;
    arm   = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    arm   = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || ram_we !== 1'b0)
      $display("FAIL abort_over_arm: got busy %b we %b, want 0 0", busy, ram_we); else passed++;
    drive_capture(4'd1, 1'b1, 8'h01, 8'h00, 8'h01, 5, -1, 20);
    wait_done(100, cyc);
    checks++; if (trig_addr !== 4'd5 || start_addr !== 4'd4)
      $display("FAIL rearm_addrs: got trig %0d start %0d, want 5 4", trig_addr, start_addr); else passed++;
    checks++; if (wr_count !== 20) $display("FAIL rearm_writes: got %0d, want 20", wr_count); else passed++;
  endtask

  task automatic test_timeout();
`ifdef CAPTURE_TIMEOUT_EN
    int cyc;
    drive_capture(4'd2, 1'b1, 8'h00, 8'hFF, 8'h00, -1, -1, 23);
    wait_done(100, cyc);
    checks++; if (done !== 1'b1) $display("FAIL tmo_done: got %b, want 1", done); else passed++;
    checks++; if (timed_out !== 1'b1) $display("FAIL tmo_flag: got %b, want 1", timed_out); else passed++;
    checks++; if (trig_addr !== 4'd9 || start_addr !== 4'd7)
      $display("FAIL tmo_addrs: got trig %0d start %0d, want 9 7", trig_addr, start_addr); else passed++;
    checks++; if (wr_count !== 23) $display("FAIL tmo_writes: got %0d, want 23", wr_count); else passed++;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    checks++; if (timed_out !== 1'b0 || done !== 1'b0)
      $display("FAIL tmo_abort_clear: got timed_out %b done %b, want 0 0", timed_out, done); else passed++;
`else
    drive_capture(4'd2, 1'b1, 8'h00, 8'hFF, 8'h00, -1, -1, 41);
    repeat (40) begin @(posedge clk); #1; end
    checks++; if ({busy, ram_we, done, timed_out} !== 4'b1100)
      $display("FAIL notmo_waiting: got %b, want 1100", {busy, ram_we, done, timed_out}); else passed++;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    checks++; if (wr_count !== 41 || busy !== 1'b0)
      $display("FAIL notmo_abort: got writes %0d busy %b, want 41 0", wr_count, busy); else passed++;
`endif
    checks++; if (addr_q.size() !== 0)
      $display("FAIL sb_leftover: got %0d pending writes, want 0", addr_q.size()); else passed++;
  endtask

  initial begin : main
    test_reset();
    test_basic_or();
    test_back_to_back();
    test_wrap();
    test_post_zero();
    test_pre_ignored();
    test_abort();
    test_timeout();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/capture_ctrl.md
# capture_ctrl

Sequencing controller for the on-chip logic-analyzer debugger. Combines the per-channel trigger flags of the channel trigger units into one trigger decision. Runs the arm / pre-trigger / wait / post-trigger capture sequence and drives the sample RAM write port as a circular buffer. Reports the trigger address and the oldest-sample address so the readout path can unroll the buffer.

## Interface
- PORT_WIDTH, 32, number of probed channels (width of data and trigger vector)
- ADDR_WIDTH, 10, sample RAM address width; DEPTH = 2**ADDR_WIDTH
- TIMEOUT_CYCLES, 1024, WAIT-state cycles before a forced trigger (used only with CAPTURE_TIMEOUT_EN)

Ports:
- clk  in  1  sample clock; everything in this block is on this clock
- rstn  in  1  asynchronous active-low reset
- arm  in  1  one-cycle start pulse
- abort  in  1  level or pulse; cancels capture
- trig_or  in  1  1: OR-combine masked channels; 0: AND-combine
- ch_mask  in  PORT_WIDTH  1 = channel participates in trigger
- pre_depth  in  ADDR_WIDTH  samples kept before the trigger; sampled on arm
- trig_vec  in  PORT_WIDTH  per-channel trigger flags (registered upstream)
- data_in  in  PORT_WIDTH  probed signals
- ram_we  out  1  sample RAM write enable
- ram_waddr  out  ADDR_WIDTH  write address
- ram_wdata  out  PORT_WIDTH  write data
- busy  out  1  high in PRE/WAIT/POST
- done  out  1  capture complete; held until next arm or abort
- trig_addr  out  ADDR_WIDTH  RAM address of the trigger sample
- start_addr  out  ADDR_WIDTH  address of oldest valid sample = trig_addr − pre_depth mod DEPTH
- timed_out  out  1  trigger was forced by timeout (constant 0 without macro)

## Operation
- Trigger hit:
  - OR mode: hit = |(trig_vec & ch_mask). ch_mask=0 never hits.
  - AND mode: hit = &(trig_vec | ~ch_mask). ch_mask=0 hits immediately.
- States and transitions:
  - IDLE → PRE on arm. If latched pre_depth = 0, go to WAIT instead.
  - PRE: writes exactly pre_depth samples, ignores hit, then → WAIT.
  - WAIT: writes every cycle. On the cycle hit=1, that cycle's sample is the trigger sample and trig_addr ← ram_waddr. → POST, or → DONE if post_len = 0.
  - POST: writes post_len = DEPTH−1−pre_depth samples, then → DONE.
  - DONE: done=1, ram_we=0. arm → PRE (new capture).
- ram_waddr starts at 0 on each arm, increments on each write, wraps DEPTH−1→0.
- pre_depth is latched on arm and is width-limited to ≤ DEPTH−1, so post_len ≥ 0 always.
- arm while busy is ignored.
- abort has priority over arm and hit in every state → IDLE; done, busy, timed_out cleared.
- Simultaneous arm and abort: abort wins.

## Timing
- Reset values: ram_we=0, ram_waddr=0, ram_wdata=0, busy=0, done=0, trig_addr=0, start_addr=0, timed_out=0; state IDLE.
- arm sampled at edge N → ram_we=1 and ram_waddr=0 from cycle N+1.
- ram_wdata = data_in delayed one register, aligned with the registered trig_vec. Any further alignment is the instantiator's job.
- Outputs are registered; ram_we is high exactly in PRE/WAIT/POST cycles.
- done rises the cycle after the last POST write, or after the trigger write when post_len=0.
- start_addr is valid when done=1.
- abort sampled at edge N → ram_we=0 and busy=0 in cycle N+1.

## Configuration
- CAPTURE_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) counts WAIT cycles.
  - On the TIMEOUT_CYCLES-th WAIT write without a hit, that sample is treated as the trigger and timed_out=1.
  - The counter clears on arm and on abort.
- Undefined: WAIT persists until hit or abort; timed_out tied to 0; no counter logic.

## Structure
- Shared debugger package holds the state enum (IDLE, PRE, WAIT, POST, DONE) and a trigger-combine mode constant (AND=0, OR=1).
- One sub-module, trig_combine: purely combinational mask-and-reduce producing hit. The sequencer (FSM, address and sample counters, timeout) stays in capture_ctrl.

## Test plan
Bench settings: ADDR_WIDTH=4 (DEPTH 16), PORT_WIDTH=8 unless stated.
- Basic OR capture: pre_depth=4, trig_or=1, ch_mask=0x01, trig_vec[0]=1 on the 10th write cycle → trig_addr=9, 21 total writes, start_addr=5, done=1.
- Wrap: pre_depth=2, hit on write index 33 → trig_addr=1, start_addr=15, 13 POST writes, addresses wrap 15→0.
- post_len=0: pre_depth=15, hit on the first WAIT cycle → trig_addr=15, done the next cycle, no POST writes.
- Trigger during PRE ignored: trig_vec held 0xFF from arm, AND mode, ch_mask=0xFF, pre_depth=3 → trig_addr=3.
- Abort mid-POST: ram_we=0, busy=0, done=0 the next cycle; re-arm writes again from address 0.
- Timeout (macro on): TIMEOUT_CYCLES=8, pre_depth=2, no hit → timed_out=1, trig_addr=9, done after 13 POST writes. Macro off: same stimulus stays in WAIT indefinitely.
